draw_scheduler: RTL
===================

# draw_scheduler

Shares the single 4x4 block-plot engine (the `control_draw` FSM plus its datapath) between `NUM_REQ` independent drawing clients and one screen-clear client. It picks one request at a time and presents that request's coordinates and colour to the engine. It then drives the engine's `enable_start`/`enable_clear` strobes and tracks `ready_to_draw` until the plot finishes. Finally it returns a one-cycle completion pulse to the winning client. It sits between the game-logic blocks (letter/word renderers) and the draw controller.

## Interface
- `NUM_REQ`, 4: number of block-draw clients, 2..8.
- `X_W`, 8: x coordinate width.
- `Y_W`, 7: y coordinate width.
- `C_W`, 3: colour width.
- `clk` in 1: single clock, all logic on the rising edge.
- `resetn` in 1: asynchronous, active-low reset.
- `req` in `NUM_REQ`: per-client draw request, level; held until that client's `done`.
- `req_x` in `NUM_REQ*X_W`: packed x, client i at `[i*X_W +: X_W]`.
- `req_y` in `NUM_REQ*Y_W`: packed y.
- `req_colour` in `NUM_REQ*C_W`: packed colour.
- `grant` out `NUM_REQ`: one-hot owner of the engine; zero when no client owns it.
- `done` out `NUM_REQ`: one-cycle pulse to the owner when its block is plotted.
- `clear_req` in 1: screen-clear request, level (macro-dependent).
- `clear_done` out 1: one-cycle pulse when the clear completes (macro-dependent).
- `ready_to_draw` in 1: from the engine; high only while the engine is idle.
- `enable_start` out 1: one-cycle block-draw strobe to the engine.
- `enable_clear` out 1: one-cycle clear strobe to the engine.
- `x` out `X_W`, `y` out `Y_W`, `colour` out `C_W`: operands to the engine, registered.
- `busy` out 1: high in every state except S_IDLE.

## Operation
- States: S_IDLE, S_ISSUE, S_WAIT_BUSY, S_WAIT_DONE.
- **S_IDLE**
  - Arbitrates only when `ready_to_draw`=1 and some request is pending.
  - `clear_req` has absolute priority over all `req` bits.
  - Otherwise the winner is picked round-robin: search starts at `last+1` and wraps modulo `NUM_REQ`.
  - On a win, these are registered: the winner's x/y/colour, one-hot `grant` (or the internal clear-owner flag), and `last`=winner. The state then goes to S_ISSUE.
  - A clear grant leaves `last` unchanged.
  - `x`/`y`/`colour` are left unchanged for a clear; the engine ignores them.
- **S_ISSUE:** lasts exactly one cycle.
  - `enable_start`=1 for a block grant; `enable_clear`=1 for a clear grant.
  - Always goes to S_WAIT_BUSY next.
- **S_WAIT_BUSY:** stays until `ready_to_draw`=0, then goes to S_WAIT_DONE.
- **S_WAIT_DONE:** stays until `ready_to_draw`=1.
  - It then pulses `done[owner]` (or `clear_done`) for one cycle, clears `grant`, and goes to S_IDLE.
- `x`/`y`/`colour`/`grant` are stable from the S_IDLE→S_ISSUE edge until the completion pulse.
- A client dropping `req` after it has been granted is ignored. The plot completes and `done` still pulses.
- A new request arriving mid-operation waits; it is arbitrated at the next S_IDLE.
- If `ready_to_draw`=0 in S_IDLE (engine busy with foreign traffic), no grant is issued.

## Timing
- Reset values:
  - State S_IDLE.
  - `grant`, `done`, `clear_done`, `enable_start`, `enable_clear`, `busy` all 0.
  - `x`, `y`, `colour` all 0.
  - `last`=`NUM_REQ-1`, so client 0 wins first.
- Reset mid-operation returns immediately to S_IDLE with no completion pulse.
  - The engine is expected to be reset by the same `resetn`.
- Request to strobe latency: request seen at edge T gives `enable_start` high during cycle T+1.
- With the current engine (LOAD 1 cycle, DRAW 17 cycles):
  - `ready_to_draw` drops at T+2.
  - `done` pulses 19 cycles after the strobe.
  - The next grant can be registered in the cycle after `done`.
- Back-to-back: no bubble beyond the one S_IDLE cycle.
- Strobes and `done` are decoded from the registered state and are glitch-free.

## Configuration
- `DRAW_SCHED_CLEAR_EN` defined:
  - `clear_req` and `clear_done` ports exist.
  - Clear has priority over all block requests as described above.
- Not defined:
  - Both ports are removed.
  - `enable_clear` is tied to 0.
  - Arbitration considers `req` only.

## Structure
- Shared package `draw_sched_pkg` holds:
  - State encodings S_IDLE..S_WAIT_DONE (2 bits).
  - Default widths `X_W`=8, `Y_W`=7, `C_W`=3, matching the 160x120 VGA adaptor.
- One sub-module, `rr_arbiter`:
  - Purely combinational, parameterised by `NUM_REQ`.
  - Inputs `req` and `last`; outputs one-hot `win` and `any`.
  - The FSM and registers live in `draw_scheduler`.

## Test plan
- Single client: `req`=0001, x=10, y=20, colour=3, engine model idle.
  - `enable_start` pulses once at T+1 with x=10, y=20, colour=3.
  - `done[0]` pulses once after the engine returns `ready_to_draw`.
- All four `req` held continuously.
  - Grants cycle 0,1,2,3,0; each `done` is paired with its own coordinates; no client is granted twice in a row.
- `clear_req` and `req`=0110 asserted in the same cycle.
  - Clear wins: `enable_clear` pulses and `enable_start` stays 0.
  - After `clear_done`, client 1 is granted next (round-robin pointer untouched).
- Client 2 drops `req` two cycles after its grant.
  - Operation completes and `done[2]` still pulses; no extra strobe.
- `ready_to_draw` held low in S_IDLE while `req`=0001.
  - No grant and `busy`=0; the grant follows one cycle after `ready_to_draw` rises.
- `resetn` pulsed low during S_WAIT_DONE.
  - All outputs are 0 immediately (asynchronous reset) with no `done` pulse.
  - After release, client 0 wins first.

Source files
------------

// File: rtl/draw_sched_pkg.sv
// Shared definitions for the draw scheduler: FSM state encoding and the
// default operand widths of the 160x120 VGA adaptor.
package draw_sched_pkg;

    typedef enum logic [1:0] {
        S_IDLE      = 2'd0,
        S_ISSUE     = 2'd1,
        S_WAIT_BUSY = 2'd2,
        S_WAIT_DONE = 2'd3
    } state_t;

    localparam int DEF_NUM_REQ = 4;
    localparam int DEF_X_W     = 8;
    localparam int DEF_Y_W     = 7;
    localparam int DEF_C_W     = 3;

endpackage

// File: rtl/draw_scheduler_rr_arbiter.sv
// Combinational round-robin arbiter: the search begins at the client after
// 'last' and wraps, so the most recent winner has the lowest priority.
module rr_arbiter #(
    parameter int NUM_REQ = 4
) (
    input  logic [NUM_REQ-1:0]         req,
    input  logic [$clog2(NUM_REQ)-1:0] last,
    output logic [NUM_REQ-1:0]         win,
    output logic                       any
);

    localparam int IDX_W = $clog2(NUM_REQ);

    logic [IDX_W-1:0] idx;

    // First requesting client found walking upward from last+1.
    always_comb begin
        // NOTE: every output of a combinational block gets a default before any
        // conditional assignment, otherwise synthesis infers a latch.
        win = '0;
        any = 1'b0;
        idx = '0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            idx = IDX_W'((int'(last) + k) % NUM_REQ);
            if (!any && req[idx]) begin
                win[idx] = 1'b1;
                any      = 1'b1;
            end
        end
    end

endmodule

// File: rtl/draw_scheduler.sv
// Shares the 4x4 block-plot engine between NUM_REQ drawing clients and,
// when DRAW_SCHED_CLEAR_EN is defined, one screen-clear client that has
// absolute priority. Without the macro the clear ports do not exist and
// enable_clear is constant 0.
module draw_scheduler
    import draw_sched_pkg::*;
#(
    parameter int NUM_REQ = DEF_NUM_REQ,
    parameter int X_W     = DEF_X_W,
    parameter int Y_W     = DEF_Y_W,
    parameter int C_W     = DEF_C_W
) (
    input  logic                   clk,
    input  logic                   resetn,
    input  logic [NUM_REQ-1:0]     req,
    input  logic [NUM_REQ*X_W-1:0] req_x,
    input  logic [NUM_REQ*Y_W-1:0] req_y,
    input  logic [NUM_REQ*C_W-1:0] req_colour,
    output logic [NUM_REQ-1:0]     grant,
    output logic [NUM_REQ-1:0]     done,
`ifdef DRAW_SCHED_CLEAR_EN
    input  logic                   clear_req,
    output logic                   clear_done,
`endif
    input  logic                   ready_to_draw,
    output logic                   enable_start,
    output logic                   enable_clear,
    output logic [X_W-1:0]         x,
    output logic [Y_W-1:0]         y,
    output logic [C_W-1:0]         colour,
    output logic                   busy
);

    localparam int IDX_W = $clog2(NUM_REQ);

    state_t             state_q, state_d;
    logic [IDX_W-1:0]   last_q;
    logic [NUM_REQ-1:0] win;
    logic               any;
    logic [IDX_W-1:0]   win_idx;
    logic [X_W-1:0]     sel_x;
    logic [Y_W-1:0]     sel_y;
    logic [C_W-1:0]     sel_c;
    logic               clear_pending;
    logic               clear_own_q;

    rr_arbiter #(.NUM_REQ(NUM_REQ)) u_arb (
        .req  (req),
        .last (last_q),
        .win  (win),
        .any  (any)
    );

    // Winner index and its operands, muxed from the packed request buses.
    always_comb begin
        win_idx = '0;
        sel_x   = '0;
        sel_y   = '0;
        sel_c   = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (win[i]) begin
                win_idx = IDX_W'(i);
                sel_x   = req_x[i*X_W +: X_W];
                sel_y   = req_y[i*Y_W +: Y_W];
                sel_c   = req_colour[i*C_W +: C_W];
            end
        end
    end

`ifdef DRAW_SCHED_CLEAR_EN
    assign clear_pending = clear_req;

    // Clear ownership flag and its completion pulse.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            clear_own_q <= 1'b0;
            clear_done  <= 1'b0;
        end else begin
            clear_done <= 1'b0;
            if (state_q == S_IDLE && ready_to_draw && clear_req) begin
                clear_own_q <= 1'b1;
            end else if (state_q == S_WAIT_DONE && ready_to_draw) begin
                clear_done  <= clear_own_q;
                clear_own_q <= 1'b0;
            end
        end
    end
`else
    assign clear_pending = 1'b0;
    assign clear_own_q   = 1'b0;
`endif

    // State register.
    always_ff @(posedge clk or negedge resetn) begin
        // NOTE: sequential state uses non-blocking assignments so every flop
        // samples pre-edge values regardless of process evaluation order.
        if (!resetn) state_q <= S_IDLE;
        else         state_q <= state_d;
    end

    // Next-state logic: arbitrate when idle, then follow the engine handshake.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:      if (ready_to_draw && (clear_pending || any)) state_d = S_ISSUE;
            S_ISSUE:     state_d = S_WAIT_BUSY;
            S_WAIT_BUSY: if (!ready_to_draw) state_d = S_WAIT_DONE;
            S_WAIT_DONE: if (ready_to_draw) state_d = S_IDLE;
            default:     state_d = S_IDLE;
        endcase
    end

    // Engine strobes and busy, decoded from registered state only.
    always_comb begin
        enable_start = (state_q == S_ISSUE) && !clear_own_q;
        enable_clear = (state_q == S_ISSUE) &&  clear_own_q;
        busy         = (state_q != S_IDLE);
    end

    // Grant, operands, round-robin pointer and block completion pulse.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            grant  <= '0;
            done   <= '0;
            x      <= '0;
            y      <= '0;
            colour <= '0;
            last_q <= IDX_W'(NUM_REQ - 1);
        end else begin
            done <= '0;
            if (state_q == S_IDLE && ready_to_draw && !clear_pending && any) begin
                grant  <= win;
                last_q <= win_idx;
                x      <= sel_x;
                y      <= sel_y;
                colour <= sel_c;
            end else if (state_q == S_WAIT_DONE && ready_to_draw) begin
                done  <= grant;
                grant <= '0;
            end
        end
    end

endmodule
